cmplx_mixer: RTL and testbench

CMPLX_MIXER -- requirements
Module: cmplx_mixer

---
 rtl/mixer_pkg.sv | 20 ++
 rtl/iq_fifo.sv | 58 +++++
 rtl/cmplx_mixer.sv | 159 +++++++++++++++
 tb/tb_cmplx_mixer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared widths, fixed-point constants and the I/Q sample type for the
// complex mixer datapath.
package mixer_pkg;

   localparam int SAMPLE_W = 16;
   localparam int PROD_W   = 32;
   localparam int SUM_W    = 33;
   localparam int FRAC_W   = 15;
   localparam int RND_W    = SUM_W - FRAC_W;

   localparam logic signed [SUM_W-1:0] RND_CONST = 33'sd16384;
   localparam logic signed [RND_W-1:0] SAT_MAX   = 18'sd32767;
   localparam logic signed [RND_W-1:0] SAT_MIN   = -18'sd32768;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] i;
      logic signed [SAMPLE_W-1:0] q;
   } iq_t;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO used to align one input stream of the mixer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers/occupancy)
//   push, din    write request and payload
//   pop, dout    read request and head-of-queue payload (combinational read)
//   full, empty  occupancy status
// A push while full is taken only when a pop happens in the same cycle.
module iq_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cmplx_mixer.sv
// Complex mixer: aligns a baseband I/Q stream with an NCO cos/sin stream
// through two FIFOs, then multiplies each pair by (cos +/- j*sin) in a
// four-stage pipeline with Q15 rounding and optional saturation.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   data_i_i, data_q_i, data_valid_i   input sample (Q15) and its valid
//   cos_i, sin_i, nco_valid_i     NCO sample (Q15) and its valid
//   conj_i                        0: up-shift, 1: down-shift (sampled at pop)
//   out_i_o, out_q_o, out_valid   mixed sample (Q15) and its valid
//   sat_o                         pulse with out_valid when a component clamped
//   ovf_o                         sticky: an input sample was dropped
module cmplx_mixer
   import mixer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter bit SAT_EN     = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] data_i_i,
   input  logic signed [SAMPLE_W-1:0] data_q_i,
   input  logic                       data_valid_i,
   input  logic signed [SAMPLE_W-1:0] cos_i,
   input  logic signed [SAMPLE_W-1:0] sin_i,
   input  logic                       nco_valid_i,
   input  logic                       conj_i,
   output logic signed [SAMPLE_W-1:0] out_i_o,
   output logic signed [SAMPLE_W-1:0] out_q_o,
   output logic                       out_valid,
   output logic                       sat_o,
   output logic                       ovf_o
);

   function automatic logic signed [RND_W-1:0] round_q15(input logic signed [SUM_W-1:0] s);
      logic signed [SUM_W-1:0] t;
      t = s + RND_CONST;
      return t[SUM_W-1:FRAC_W];
   endfunction

   // Returns {clamped, value}.
   function automatic logic [SAMPLE_W:0] sat16(input logic signed [RND_W-1:0] r);
      if (SAT_EN && (r > SAT_MAX))      return {1'b1, SAT_MAX[SAMPLE_W-1:0]};
      else if (SAT_EN && (r < SAT_MIN)) return {1'b1, SAT_MIN[SAMPLE_W-1:0]};
      else                              return {1'b0, r[SAMPLE_W-1:0]};
   endfunction

   iq_t                      d_push;
   iq_t                      n_push;
   logic [2*SAMPLE_W-1:0]    d_head;
   logic [2*SAMPLE_W-1:0]    n_head;
   iq_t                      d_pop;
   iq_t                      n_pop;
   logic                     d_full, d_empty, n_full, n_empty;
   logic                     pop;
   logic                     drop;

   logic signed [SAMPLE_W-1:0] di_p0, dq_p0, cs_p0, sn_p0;
   logic                       conj_p0, vld_p0;
   logic signed [PROD_W-1:0]   ic_p1, qs_p1, is_p1, qc_p1;
   logic                       conj_p1, vld_p1;
   logic signed [SUM_W-1:0]    si_p2, sq_p2;
   logic                       vld_p2;

   logic signed [RND_W-1:0]    ri, rq;
   logic [SAMPLE_W:0]          fi, fq;

   assign d_push = '{i: data_i_i, q: data_q_i};
   assign n_push = '{i: cos_i, q: sin_i};
   assign d_pop  = iq_t'(d_head);
   assign n_pop  = iq_t'(n_head);

   // Pairing is strictly in order: pop both heads together or neither.
   assign pop  = !d_empty && !n_empty;
   assign drop = (data_valid_i && d_full && !pop) || (nco_valid_i && n_full && !pop);

   iq_fifo #(.DEPTH(FIFO_DEPTH), .W(2*SAMPLE_W)) u_data_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_valid_i),
      .pop   (pop),
      .din   (d_push),
      .dout  (d_head),
      .full  (d_full),
      .empty (d_empty)
   );

   iq_fifo #(.DEPTH(FIFO_DEPTH), .W(2*SAMPLE_W)) u_nco_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (nco_valid_i),
      .pop   (pop),
      .din   (n_push),
      .dout  (n_head),
      .full  (n_full),
      .empty (n_empty)
   );

   always_ff @(posedge clk) begin
      // S1: register the popped pair and its conj selection
      if (pop) begin
         di_p0   <= d_pop.i;
         dq_p0   <= d_pop.q;
         cs_p0   <= n_pop.i;
         sn_p0   <= n_pop.q;
         conj_p0 <= conj_i;
      end
      // S2: four full-precision products
      if (vld_p0) begin
         ic_p1   <= PROD_W'(di_p0) * PROD_W'(cs_p0);
         qs_p1   <= PROD_W'(dq_p0) * PROD_W'(sn_p0);
         is_p1   <= PROD_W'(di_p0) * PROD_W'(sn_p0);
         qc_p1   <= PROD_W'(dq_p0) * PROD_W'(cs_p0);
         conj_p1 <= conj_p0;
      end
      // S3: combine products, sign chosen by conj
      if (vld_p1) begin
         if (conj_p1) begin
            si_p2 <= SUM_W'(ic_p1) + SUM_W'(qs_p1);
            sq_p2 <= SUM_W'(qc_p1) - SUM_W'(is_p1);
         end else begin
            si_p2 <= SUM_W'(ic_p1) - SUM_W'(qs_p1);
            sq_p2 <= SUM_W'(is_p1) + SUM_W'(qc_p1);
         end
      end
   end

   // S4: round to Q15, then saturate or wrap
   always_comb begin
      ri = round_q15(si_p2);
      rq = round_q15(sq_p2);
      fi = sat16(ri);
      fq = sat16(rq);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         out_valid <= 1'b0;
         sat_o     <= 1'b0;
         ovf_o     <= 1'b0;
         out_i_o   <= '0;
         out_q_o   <= '0;
      end else begin
         vld_p0    <= pop;
         vld_p1    <= vld_p0;
         vld_p2    <= vld_p1;
         out_valid <= vld_p2;
         sat_o     <= vld_p2 && (fi[SAMPLE_W] || fq[SAMPLE_W]);
         if (vld_p2) begin
            out_i_o <= fi[SAMPLE_W-1:0];
            out_q_o <= fq[SAMPLE_W-1:0];
         end
         if (drop) ovf_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cmplx_mixer.sv
module tb_cmplx_mixer;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] data_i_i, data_q_i, cos_i, sin_i;
   logic               data_valid_i, nco_valid_i, conj_i;
   logic signed [15:0] out_i_o, out_q_o, w_out_i, w_out_q;
   logic               out_valid, sat_o, ovf_o, w_valid, w_sat, w_ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int q_i[$], q_q[$], q_s[$], q_c[$], q_wi[$], q_ws[$];
   int e_i[$], e_q[$], e_s[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cmplx_mixer #(.FIFO_DEPTH(8), .SAT_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .data_i_i(data_i_i), .data_q_i(data_q_i), .data_valid_i(data_valid_i),
      .cos_i(cos_i), .sin_i(sin_i), .nco_valid_i(nco_valid_i), .conj_i(conj_i),
      .out_i_o(out_i_o), .out_q_o(out_q_o), .out_valid(out_valid),
      .sat_o(sat_o), .ovf_o(ovf_o)
   );

   cmplx_mixer #(.FIFO_DEPTH(8), .SAT_EN(1'b0)) dut_w (
      .clk(clk), .rst(rst),
      .data_i_i(data_i_i), .data_q_i(data_q_i), .data_valid_i(data_valid_i),
      .cos_i(cos_i), .sin_i(sin_i), .nco_valid_i(nco_valid_i), .conj_i(conj_i),
      .out_i_o(w_out_i), .out_q_o(w_out_q), .out_valid(w_valid),
      .sat_o(w_sat), .ovf_o(w_ovf)
   );

   always @(negedge clk) begin
      if (out_valid) begin
         q_i.push_back(out_i_o);
         q_q.push_back(out_q_o);
         q_s.push_back(sat_o);
         q_c.push_back(cyc);
      end
      if (w_valid) begin
         q_wi.push_back(w_out_i);
         q_ws.push_back(w_sat);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic clear_q();
      q_i.delete(); q_q.delete(); q_s.delete(); q_c.delete();
      q_wi.delete(); q_ws.delete();
   endtask

   task automatic drive(input int di, input int dq, input int c, input int s,
                        input bit cj, input bit dv, input bit nv);
      @(negedge clk);
      data_i_i = 16'(di); data_q_i = 16'(dq);
      cos_i = 16'(c); sin_i = 16'(s);
      conj_i = cj; data_valid_i = dv; nco_valid_i = nv;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_valid_i = 1'b0; nco_valid_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      data_valid_i = 1'b0; nco_valid_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
   endtask

   // One pair expected: saturating DUT i/q/sat, wrapping DUT i/sat.
   task automatic chk_pair(input string tag, input int ei, input int eq, input int es,
                           input int ewi);
      chk({tag, ".count"}, q_i.size(), 1);
      chk({tag, ".wcount"}, q_wi.size(), 1);
      if (q_i.size() > 0) begin
         chk({tag, ".i"}, q_i[0], ei);
         chk({tag, ".q"}, q_q[0], eq);
         chk({tag, ".sat"}, q_s[0], es);
      end
      if (q_wi.size() > 0) begin
         chk({tag, ".wrap_i"}, q_wi[0], ewi);
         chk({tag, ".wrap_sat"}, q_ws[0], 0);
      end
      clear_q();
   endtask

   function automatic int clamp16(input longint v, inout bit st);
      if (v > 32767) begin st = 1'b1; return 32767; end
      if (v < -32768) begin st = 1'b1; return -32768; end
      return int'(v);
   endfunction

   // Reference: exact complex product, round half up at 2^-15, clamp.
   function automatic void mix_model(input int di, input int dq, input int c, input int s,
                                     input bit cj, output int oi, output int oq, output bit st);
      longint a, b;
      if (!cj) begin
         a = longint'(di) * c - longint'(dq) * s;
         b = longint'(di) * s + longint'(dq) * c;
      end else begin
         a = longint'(di) * c + longint'(dq) * s;
         b = longint'(dq) * c - longint'(di) * s;
      end
      a = (a + 16384) >>> 15;
      b = (b + 16384) >>> 15;
      st = 1'b0;
      oi = clamp16(a, st);
      oq = clamp16(b, st);
   endfunction

   function automatic int rnd16(input int k);
      logic signed [15:0] t;
      t = 16'($urandom);
      if (k % 97 == 0)  t = -16'sd32768;
      if (k % 101 == 0) t = 16'sd32767;
      return int'(t);
   endfunction

   initial begin
      int t0, ei, eq, n, di, dq, c, s;
      bit es;

      rst = 1'b1;
      data_i_i = '0; data_q_i = '0; cos_i = '0; sin_i = '0;
      data_valid_i = 1'b0; nco_valid_i = 1'b0; conj_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.sat", sat_o, 0);
      chk("rst.ovf", ovf_o, 0);
      chk("rst.out_i", out_i_o, 0);
      chk("rst.out_q", out_q_o, 0);
      rst = 1'b0;
      clear_q();

      // Single pair, unity-ish gain; push at drive edge, pop next cycle, out 4 later.
      drive(32767, 0, 32767, 0, 1'b0, 1'b1, 1'b1);
      t0 = cyc;
      idle(12);
      chk("basic.latency", (q_c.size() > 0) ? (q_c[0] - t0) : -1, 5);
      chk_pair("basic", 32766, 0, 0, 32766);

      drive(32767, 32767, 32767, 32767, 1'b0, 1'b1, 1'b1);
      idle(12);
      chk_pair("full_up", 0, 32767, 1, 0);

      drive(32767, 32767, 32767, 32767, 1'b1, 1'b1, 1'b1);
      idle(12);
      chk_pair("full_dn", 32767, 0, 1, -4);

      drive(16384, 8192, 16384, -8192, 1'b1, 1'b1, 1'b1);
      idle(12);
      chk_pair("conj_mix", 6144, 8192, 0, 6144);

      drive(-32768, 0, -32768, 0, 1'b0, 1'b1, 1'b1);
      idle(12);
      chk_pair("neg_full", 32767, 0, 1, -32768);

      // Overflow: 10 data samples into an 8-deep FIFO with no NCO.
      for (int k = 1; k <= 10; k++) begin
         drive(k * 1000, 0, 0, 0, 1'b0, 1'b1, 1'b0);
         if (k == 9)  chk("ovf.after8", ovf_o, 0);
         if (k == 10) chk("ovf.after9", ovf_o, 1);
      end
      for (int k = 1; k <= 10; k++) drive(0, 0, 32767, 0, 1'b0, 1'b0, 1'b1);
      idle(12);
      chk("ovf.count", q_i.size(), 8);
      for (int k = 0; k < q_i.size() && k < 8; k++) begin
         chk($sformatf("ovf.i%0d", k), q_i[k], (k + 1) * 1000);
         chk($sformatf("ovf.q%0d", k), q_q[k], 0);
      end
      chk("ovf.sticky", ovf_o, 1);
      do_reset();
      chk("ovf.cleared", ovf_o, 0);

      // Continuous stream against the reference model.
      for (int k = 0; k < 1000; k++) begin
         di = rnd16(k); dq = rnd16(k + 3); c = rnd16(k + 7); s = rnd16(k + 11);
         drive(di, dq, c, s, 1'b0, 1'b1, 1'b1);
         mix_model(di, dq, c, s, 1'b0, ei, eq, es);
         e_i.push_back(ei); e_q.push_back(eq); e_s.push_back(int'(es));
      end
      idle(12);
      chk("stream.count", q_i.size(), 1000);
      n = (q_i.size() < 1000) ? q_i.size() : 1000;
      for (int k = 0; k < n; k++) begin
         chk($sformatf("stream.i%0d", k), q_i[k], e_i[k]);
         chk($sformatf("stream.q%0d", k), q_q[k], e_q[k]);
         chk($sformatf("stream.sat%0d", k), q_s[k], e_s[k]);
      end
      chk("stream.span", (n > 0) ? (q_c[n-1] - q_c[0]) : -1, 999);
      chk("stream.ovf", ovf_o, 0);
      clear_q();

      // Reset with 3 pairs in the pipeline and 2 data samples still buffered.
      for (int k = 0; k < 5; k++) drive(32767, 32767, 0, 0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) drive(0, 0, 32767, 32767, 1'b0, 1'b0, 1'b1);
      idle(1);
      chk("midrst.none_yet", q_i.size(), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
      idle(15);
      chk("midrst.no_valid", q_i.size(), 0);
      chk("midrst.ovf", ovf_o, 0);
      chk("midrst.sat", sat_o, 0);
      chk("midrst.out_i", out_i_o, 0);
      chk("midrst.out_q", out_q_o, 0);
      drive(16384, 0, 16384, 0, 1'b0, 1'b1, 1'b1);
      idle(12);
      chk_pair("post_rst", 8192, 0, 0, 8192);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
